// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between instruction fetch, the issue stage, the ALU and write-back.
// The stage itself takes the slave view; the environment drives through the master view.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [31:0] out_src0;
  logic [31:0] out_src1;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  modport slave (
    input  in_valid, in_inst, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, out_op, out_src0, out_src1, out_rd, out_we, out_illegal
  );

  modport master (
    output in_valid, in_inst, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, out_op, out_src0, out_src1, out_rd, out_we, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// LA32R integer-ALU decode/issue stage: decode, register-file read with write-through,
// busy scoreboard for RAW/WAW hazards, and a single valid/ready output register.
module alu_issue_stage #(
  parameter bit         RESET_RF   = 1'b1,
  parameter logic [3:0] ILLEGAL_OP = 4'h0,
  parameter bit         USE_SB     = 1'b1
) (
  input logic              clk,
  input logic              rstn,
  alu_issue_stage_if.slave bus
);

  logic [31:0] inst;
  logic [4:0]  rd, rj, rk;
  logic [16:0] key17;
  logic [9:0]  key10;
  logic [6:0]  key7;

  assign inst  = bus.in_inst;
  assign rd    = inst[4:0];
  assign rj    = inst[9:5];
  assign rk    = inst[14:10];
  assign key17 = inst[31:15];
  assign key10 = inst[31:22];
  assign key7  = inst[31:25];

  logic        is_3r, is_shi, is_si12, is_zi12, is_lui;
  logic [3:0]  dec_op;
  logic        dec_ill, dec_we, use_rj, use_rk;
  logic [31:0] dec_imm;

  // The three key fields never alias one another, so at most one format matches.
  always_comb begin
    is_3r   = 1'b0;
    is_shi  = 1'b0;
    is_si12 = 1'b0;
    is_zi12 = 1'b0;
    is_lui  = 1'b0;
    dec_op  = ILLEGAL_OP;
    case (key17)
      17'h00020: begin is_3r  = 1'b1; dec_op = 4'h0; end
      17'h00022: begin is_3r  = 1'b1; dec_op = 4'h1; end
      17'h00024: begin is_3r  = 1'b1; dec_op = 4'h2; end
      17'h00025: begin is_3r  = 1'b1; dec_op = 4'h3; end
      17'h00028: begin is_3r  = 1'b1; dec_op = 4'h6; end
      17'h00029: begin is_3r  = 1'b1; dec_op = 4'h4; end
      17'h0002A: begin is_3r  = 1'b1; dec_op = 4'h5; end
      17'h0002B: begin is_3r  = 1'b1; dec_op = 4'h7; end
      17'h0002E: begin is_3r  = 1'b1; dec_op = 4'h8; end
      17'h0002F: begin is_3r  = 1'b1; dec_op = 4'h9; end
      17'h00030: begin is_3r  = 1'b1; dec_op = 4'hA; end
      17'h00081: begin is_shi = 1'b1; dec_op = 4'h8; end
      17'h00089: begin is_shi = 1'b1; dec_op = 4'h9; end
      17'h00091: begin is_shi = 1'b1; dec_op = 4'hA; end
      default: ;
    endcase
    case (key10)
      10'h008: begin is_si12 = 1'b1; dec_op = 4'h2; end
      10'h009: begin is_si12 = 1'b1; dec_op = 4'h3; end
      10'h00A: begin is_si12 = 1'b1; dec_op = 4'h0; end
      10'h00D: begin is_zi12 = 1'b1; dec_op = 4'h4; end
      10'h00E: begin is_zi12 = 1'b1; dec_op = 4'h5; end
      10'h00F: begin is_zi12 = 1'b1; dec_op = 4'h7; end
      default: ;
    endcase
    if (key7 == 7'h0A) begin
      is_lui = 1'b1;
      dec_op = 4'hB;
    end

    use_rj  = is_3r | is_shi | is_si12 | is_zi12;
    use_rk  = is_3r;
    dec_ill = ~(is_3r | is_shi | is_si12 | is_zi12 | is_lui);
    dec_we  = ~dec_ill & (rd != '0);

    dec_imm = '0;
    if (is_shi)  dec_imm = {27'b0, rk};
    if (is_si12) dec_imm = {{20{inst[21]}}, inst[21:10]};
    if (is_zi12) dec_imm = {20'b0, inst[21:10]};
    if (is_lui)  dec_imm = {inst[24:5], 12'b0};
  end

  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [31:0] rj_val, rk_val, src0, src1;

  assign rf_we = bus.wb_en & (bus.wb_addr != '0);

  always_comb begin
    rj_val = '0;
    rk_val = '0;
    if (rj != '0) rj_val = (bus.wb_en && bus.wb_addr == rj) ? bus.wb_data : rf_q[rj];
    if (rk != '0) rk_val = (bus.wb_en && bus.wb_addr == rk) ? bus.wb_data : rf_q[rk];
  end

  assign src0 = use_rj ? rj_val : '0;
  assign src1 = use_rk ? rk_val : dec_imm;

  if (RESET_RF) begin : g_rf_reset
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rf_q <= '{default: '0};
      end else if (rf_we) begin
        rf_q[bus.wb_addr] <= bus.wb_data;
      end
    end
  end else begin : g_rf_noreset
    always_ff @(posedge clk) begin
      if (rf_we) rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  logic [31:0] busy_q, busy_d, busy_eff, wb_clr;
  logic        hazard, issue_ok, accept;
  logic        out_valid_q;

  // A write-back landing this cycle releases its register for the hazard check.
  assign wb_clr   = bus.wb_en ? (32'd1 << bus.wb_addr) : '0;
  assign busy_eff = busy_q & ~wb_clr;
  assign hazard   = (use_rj & busy_eff[rj]) | (use_rk & busy_eff[rk]) | (dec_we & busy_eff[rd]);
  assign issue_ok = ~(USE_SB & hazard);

  assign bus.in_ready = issue_ok & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign busy_d       = busy_eff | ((accept & dec_we) ? (32'd1 << rd) : '0);

  logic [3:0]  out_op_q;
  logic [31:0] out_src0_q, out_src1_q;
  logic [4:0]  out_rd_q;
  logic        out_we_q, out_ill_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_src0_q  <= '0;
      out_src1_q  <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
      out_ill_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_op_q    <= dec_op;
        out_src0_q  <= src0;
        out_src1_q  <= src1;
        out_rd_q    <= rd;
        out_we_q    <= dec_we;
        out_ill_q   <= dec_ill;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_op      = out_op_q;
  assign bus.out_src0    = out_src0_q;
  assign bus.out_src1    = out_src1_q;
  assign bus.out_rd      = out_rd_q;
  assign bus.out_we      = out_we_q;
  assign bus.out_illegal = out_ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized checks of alu_issue_stage against an instruction-level model
// (mnemonic table, register-file array, plain-arithmetic ALU).
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage #(.RESET_RF(1'b1), .ILLEGAL_OP(4'h0), .USE_SB(1'b1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Mnemonics: 0 add,1 sub,2 slt,3 sltu,4 nor,5 and,6 or,7 xor,8 sll,9 srl,10 sra,
  // 11 slli,12 srli,13 srai,14 slti,15 sltui,16 addi,17 andi,18 ori,19 xori,20 lu12i
  localparam int NM = 21;
  localparam int FMT [NM] = '{0,0,0,0,0,0,0,0,0,0,0, 1,1,1, 2,2,2, 3,3,3, 4};
  localparam logic [16:0] KEY [NM] = '{17'h20,17'h22,17'h24,17'h25,17'h28,17'h29,17'h2A,
                                      17'h2B,17'h2E,17'h2F,17'h30,17'h81,17'h89,17'h91,
                                      17'h008,17'h009,17'h00A,17'h00D,17'h00E,17'h00F,17'h0A};
  localparam logic [3:0] OPC [NM] = '{4'h0,4'h1,4'h2,4'h3,4'h6,4'h4,4'h5,4'h7,4'h8,4'h9,4'hA,
                                     4'h8,4'h9,4'hA,4'h2,4'h3,4'h0,4'h4,4'h5,4'h7,4'hB};
  localparam int I_ADD = 0, I_SUB = 1, I_OR = 6, I_XOR = 7, I_SLLI = 11, I_ORI = 18, I_LU12I = 20;

  logic [31:0] m_rf [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] encode(input int m, input logic [4:0] rd, rj, rk,
                                         input logic [31:0] imm);
    logic [16:0] k;
    k = KEY[m];
    case (FMT[m])
      0:       return {k, rk, rj, rd};
      1:       return {k, imm[4:0], rj, rd};
      2, 3:    return {k[9:0], imm[11:0], rj, rd};
      default: return {k[6:0], imm[19:0], rd};
    endcase
  endfunction

  function automatic void expect_of(input int m, input logic [4:0] rd, rj, rk,
                                    input logic [31:0] imm, output logic [3:0] op,
                                    output logic [31:0] s0, output logic [31:0] s1,
                                    output logic we);
    op = OPC[m];
    s0 = (FMT[m] == 4) ? 32'd0 : m_rf[rj];
    case (FMT[m])
      0:       s1 = m_rf[rk];
      1:       s1 = 32'(imm[4:0]);
      2:       s1 = 32'($signed(imm[11:0]));
      3:       s1 = 32'(imm[11:0]);
      default: s1 = 32'(imm[19:0]) * 32'd4096;
    endcase
    we = (rd != 5'd0);
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3: return (a < b) ? 32'd1 : 32'd0;
      4'h4: return a & b;
      4'h5: return a | b;
      4'h6: return ~(a | b);
      4'h7: return a ^ b;
      4'h8: return a << b[4:0];
      4'h9: return a >> b[4:0];
      4'hA: return $unsigned($signed(a) >>> b[4:0]);
      default: return b;
    endcase
  endfunction

  task automatic mwb(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) m_rf[a] = d;
  endtask

  task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    mwb(a, d);
    @(negedge clk);
    bus.wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] inst, input logic wbe, input logic [4:0] wa,
                       input logic [31:0] wd, output logic ok);
    int unsigned w;
    w = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_inst = inst;
    bus.wb_en = wbe; bus.wb_addr = wa; bus.wb_data = wd;
    #1;
    while (!bus.in_ready && w < 8) begin
      @(negedge clk);
      bus.wb_en = 1'b0;
      w++;
      #1;
    end
    ok = bus.in_ready;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.wb_en = 1'b0;
  endtask

  task automatic chk_bundle(input string tag, input logic [3:0] op, input logic [31:0] s0,
                            input logic [31:0] s1, input logic [4:0] rd, input logic we);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".op"}, 32'(bus.out_op), 32'(op));
    chk({tag, ".src0"}, bus.out_src0, s0);
    chk({tag, ".src1"}, bus.out_src1, s1);
    chk({tag, ".rd"}, 32'(bus.out_rd), 32'(rd));
    chk({tag, ".we"}, 32'(bus.out_we), 32'(we));
    chk({tag, ".ill"}, 32'(bus.out_illegal), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok;
    logic [3:0]  e_op;
    logic [31:0] e_s0, e_s1, imm, inst;
    logic        e_we;
    logic [4:0]  rd, rj, rk;
    int          m;
    logic        pend_v;
    logic [4:0]  pend_rd;
    logic [31:0] pend_val;

    foreach (m_rf[i]) m_rf[i] = '0;
    rstn = 1'b0;
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.out_ready = 1'b1;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.valid", 32'(bus.out_valid), 32'd0);
    chk("rst.op", 32'(bus.out_op), 32'd0);
    chk("rst.src0", bus.out_src0, 32'd0);
    chk("rst.src1", bus.out_src1, 32'd0);
    chk("rst.rd", 32'(bus.out_rd), 32'd0);
    chk("rst.we", 32'(bus.out_we), 32'd0);
    chk("rst.ill", 32'(bus.out_illegal), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    do_wb(5'd5, 32'h7FFFFFFF);
    do_wb(5'd6, 32'h00000001);

    // add.w r4,r5,r6 leaves r4 busy for the RAW stall that follows
    issue(encode(I_ADD, 5'd4, 5'd5, 5'd6, '0), 1'b0, '0, '0, ok);
    chk("add.accept", 32'(ok), 32'd1);
    chk_bundle("add", 4'h0, 32'h7FFFFFFF, 32'h1, 5'd4, 1'b1);

    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_inst = encode(I_SUB, 5'd10, 5'd4, 5'd4, '0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("raw.stall", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'hCAFEF00D;
    mwb(5'd4, 32'hCAFEF00D);
    #1;
    chk("raw.bypass_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.wb_en = 1'b0;
    chk_bundle("sub", 4'h1, 32'hCAFEF00D, 32'hCAFEF00D, 5'd10, 1'b1);
    do_wb(5'd10, 32'h0);

    issue(32'h02BFFC07, 1'b0, '0, '0, ok);
    chk("addi.accept", 32'(ok), 32'd1);
    chk_bundle("addi", 4'h0, 32'h0, 32'hFFFFFFFF, 5'd7, 1'b1);
    do_wb(5'd7, 32'hFFFFFFFF);

    issue(encode(I_ORI, 5'd7, 5'd0, 5'd0, 32'hFFF), 1'b0, '0, '0, ok);
    chk("ori.accept", 32'(ok), 32'd1);
    chk_bundle("ori", 4'h5, 32'h0, 32'h00000FFF, 5'd7, 1'b1);
    do_wb(5'd7, 32'h00000FFF);

    issue(encode(I_LU12I, 5'd8, 5'd0, 5'd0, 32'h12345), 1'b0, '0, '0, ok);
    chk("lu12i.accept", 32'(ok), 32'd1);
    chk_bundle("lu12i", 4'hB, 32'h0, 32'h12345000, 5'd8, 1'b1);
    do_wb(5'd8, 32'h12345000);

    issue(encode(I_SLLI, 5'd9, 5'd5, 5'd0, 32'd31), 1'b0, '0, '0, ok);
    chk("slli.accept", 32'(ok), 32'd1);
    chk_bundle("slli", 4'h8, 32'h7FFFFFFF, 32'd31, 5'd9, 1'b1);
    do_wb(5'd9, 32'h80000000);

    // Back-pressure: bundle held while out_ready is low, then one bundle per cycle
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue(encode(I_ADD, 5'd12, 5'd5, 5'd6, '0), 1'b0, '0, '0, ok);
    chk("bp.accept", 32'(ok), 32'd1);
    chk_bundle("bp.a", 4'h0, 32'h7FFFFFFF, 32'h1, 5'd12, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_inst = encode(I_OR, 5'd11, 5'd5, 5'd6, '0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp.hold_rd", 32'(bus.out_rd), 32'd12);
      chk("bp.hold_src0", bus.out_src0, 32'h7FFFFFFF);
      chk("bp.hold_valid", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    chk_bundle("bp.b", 4'h5, 32'h7FFFFFFF, 32'h1, 5'd11, 1'b1);
    @(negedge clk);
    bus.in_inst = encode(I_XOR, 5'd13, 5'd5, 5'd6, '0);
    #1;
    chk("bp.c_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk_bundle("bp.c", 4'h7, 32'h7FFFFFFF, 32'h1, 5'd13, 1'b1);
    @(posedge clk); #1;
    chk("bp.drain", 32'(bus.out_valid), 32'd0);
    do_wb(5'd12, 32'h80000000);
    do_wb(5'd11, 32'h7FFFFFFF);
    do_wb(5'd13, 32'h7FFFFFFE);

    // Illegal word: rd field is r31, which must not become busy
    issue(32'hFFFFFFFF, 1'b0, '0, '0, ok);
    chk("ill.accept", 32'(ok), 32'd1);
    chk("ill.valid", 32'(bus.out_valid), 32'd1);
    chk("ill.flag", 32'(bus.out_illegal), 32'd1);
    chk("ill.we", 32'(bus.out_we), 32'd0);
    chk("ill.op", 32'(bus.out_op), 32'd0);
    chk("ill.src0", bus.out_src0, 32'd0);
    chk("ill.src1", bus.out_src1, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_inst = encode(I_ADD, 5'd1, 5'd31, 5'd31, '0);
    #1;
    chk("ill.busy_untouched", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk_bundle("ill.next", 4'h0, m_rf[31], m_rf[31], 5'd1, 1'b1);
    do_wb(5'd1, 32'h0);

    // Random instruction stream; each result is written back in the next issue cycle
    pend_v = 1'b0; pend_rd = '0; pend_val = '0;
    for (int i = 0; i < 60; i++) begin
      m   = int'($urandom_range(0, NM - 1));
      rd  = 5'($urandom); rj = 5'($urandom); rk = 5'($urandom);
      imm = $urandom;
      if (pend_v) mwb(pend_rd, pend_val);
      expect_of(m, rd, rj, rk, imm, e_op, e_s0, e_s1, e_we);
      inst = encode(m, rd, rj, rk, imm);
      issue(inst, pend_v, pend_rd, pend_val, ok);
      chk("rnd.accept", 32'(ok), 32'd1);
      chk_bundle("rnd", e_op, e_s0, e_s1, rd, e_we);
      pend_v   = e_we;
      pend_rd  = rd;
      pend_val = alu(e_op, e_s0, e_s1);
    end
    if (pend_v) do_wb(pend_rd, pend_val);

    // Reset pulse while a bundle is held and a RAW stall is pending
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue(encode(I_ADD, 5'd14, 5'd5, 5'd6, '0), 1'b0, '0, '0, ok);
    chk("rst2.accept", 32'(ok), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_inst = encode(I_SUB, 5'd15, 5'd14, 5'd14, '0);
    #1;
    chk("rst2.stall", 32'(bus.in_ready), 32'd0);
    rstn = 1'b0;
    #1;
    chk("rst2.valid", 32'(bus.out_valid), 32'd0);
    chk("rst2.rd", 32'(bus.out_rd), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    foreach (m_rf[i]) m_rf[i] = '0;
    #1;
    chk("rst2.busy_cleared", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk_bundle("rst2.sub", 4'h1, 32'd0, 32'd0, 5'd15, 1'b1);
    do_wb(5'd15, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
